score_accumulator: RTL and testbench
====================================

# score_accumulator

Downstream of the per-note comparison stage. Consumes one 0–10 score per compared note and keeps running totals for the current song: note count, score total, and count of full-credit hits. On end of song it computes an integer grade percentage using a sequential restoring divider. Results drive the display/UART reporting logic.

## Interface
- NOTE_MAX, 1023: saturation limit for note and hit counters. It must fit in 10 bits.
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset; overrides enable.
- enable  in  1  when low, every register holds its value (rst still acts).
- song_start  in  1  one-cycle pulse; clears all accumulation and returns to ACCUM.
- song_end  in  1  one-cycle pulse; requests the final grade computation.
- score_ready  in  1  from comparison stage; a score is taken on its rising edge only.
- score  in  4  score for the note (legal values 0, 5, 7, 10).
- note_count  out  10  notes accepted this song.
- total  out  14  sum of accepted scores.
- hit_count  out  10  notes accepted with score 10.
- last_score  out  4  most recently accepted score.
- saturated  out  1  sticky; set when a score edge arrives while note_count == NOTE_MAX.
- busy  out  1  high in LOAD and DIVIDE.
- grade_percent  out  7  floor(total*10 / note_count), range 0..100.
- grade_valid  out  1  high in DONE.

## Operation
- States: ACCUM (reset state), LOAD, DIVIDE, DONE.
- Edge detect: score_q registers score_ready when enable is high. An accept event is score_ready & ~score_q. A level held high counts once.
- Accept in ACCUM, when note_count < NOTE_MAX:
  - note_count+1, total+clamp(score), last_score<=clamp(score).
  - hit_count+1 if clamp(score)==10.
  - clamp: values 11–15 become 10.
- Accept in ACCUM at note_count == NOTE_MAX: counters unchanged, saturated <= 1.
- Accept events in LOAD, DIVIDE or DONE are ignored. Counters and saturated are unchanged.
- ACCUM -> LOAD on song_end. A same-cycle accept event is still applied, so it is included in the grade.
- LOAD:
  - If note_count==0: grade_percent <= 0, go to DONE.
  - Otherwise: load the 17-bit numerator total*10 (computed as (total<<3)+(total<<1)), load the 10-bit divisor note_count, clear the 11-bit remainder and the 5-bit iteration counter, go to DIVIDE.
- DIVIDE: one restoring-division step per cycle, MSB first, for exactly 17 cycles. After the 17th step, grade_percent <= quotient[6:0] (quotient ≤ 100 is guaranteed), go to DONE.
- DONE: hold all outputs. Leaves only on song_start or rst.
- song_start in any state: note_count, total, hit_count, last_score, saturated and grade_percent go to 0; state goes to ACCUM. song_start wins over a simultaneous song_end and a simultaneous accept event (both are dropped).
- song_end outside ACCUM is ignored.
- Reset values: all outputs 0, state ACCUM, score_q 0, divider registers 0. rst mid-DIVIDE aborts the division and grade_valid stays 0.

## Timing
- Accept event seen at edge N: counters update at edge N, visible from cycle N+1.
- song_end sampled at edge N:
  - busy is high from N+1.
  - With note_count>0: 17 DIVIDE cycles follow LOAD. grade_valid and grade_percent are valid from N+19, and busy falls at the same time.
  - With note_count==0: grade_valid is high from N+2 with percent 0.
- grade_percent changes only at the LOAD/DIVIDE->DONE transition, on song_start, or on rst. It never shows partial quotients.
- enable low stretches every latency by the number of disabled cycles.

## Test plan
- Reset then scores 10, 7, 5, 0 (one-cycle score_ready pulses), then song_end: note_count=4, total=22, hit_count=1, last_score=0, then grade_percent=55 with grade_valid rising exactly 19 cycles after song_end.
- Scores 10, 10, 7, with score_ready held high 5 cycles on the second note, then song_end: note_count=3 (held level counted once), total=27, grade_percent=90.
- song_end with no scores accepted: grade_valid high 2 cycles later, grade_percent=0, busy never observed high beyond LOAD.
- Accept edge for score 10 on the same cycle as song_end after a prior 0: total=10, count=2, grade_percent=50. Score pulse during DIVIDE: counters unchanged, result still 50.
- NOTE_MAX=3 build, 4 score pulses of 7: note_count=3, total=21, saturated=1, grade_percent=70. song_start then clears all outputs to 0.
- rst asserted at DIVIDE cycle 8: next cycle state ACCUM, grade_valid=0, all counters 0. A following single score 5 with song_end gives grade_percent=50.

Source files
------------

// File: rtl/score_accumulator.sv
// Per-song score accumulator: running note/score/hit totals, then a grade
// percentage floor(total*10/note_count) from a 17-step restoring divider.
module score_accumulator #(
  parameter int unsigned NOTE_MAX = 1023
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       song_start,
  input  logic       song_end,
  input  logic       score_ready,
  input  logic [3:0] score,
  output logic [9:0] note_count,
  output logic [13:0] total,
  output logic [9:0] hit_count,
  output logic [3:0] last_score,
  output logic       saturated,
  output logic       busy,
  output logic [6:0] grade_percent,
  output logic       grade_valid
);

  typedef enum logic [1:0] {ACCUM, LOAD, DIVIDE, DONE} state_t;

  localparam logic [9:0] NOTE_LIMIT = NOTE_MAX[9:0];

  state_t      state_q, state_d;
  logic        score_q, score_d;
  logic [9:0]  cnt_q, cnt_d;
  logic [13:0] total_q, total_d;
  logic [9:0]  hit_q, hit_d;
  logic [3:0]  last_q, last_d;
  logic        sat_q, sat_d;
  logic [6:0]  grade_q, grade_d;
  logic [16:0] num_q, num_d;
  logic [9:0]  div_q, div_d;
  logic [10:0] rem_q, rem_d;
  logic [4:0]  iter_q, iter_d;

  logic        accept;
  logic [3:0]  score_c;
  logic [10:0] rem_shift;
  logic        q_bit;
  logic [16:0] total_ext;

  assign accept    = score_ready & ~score_q;
  assign score_c   = (score > 4'd10) ? 4'd10 : score;
  assign total_ext = {3'b000, total_q};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ACCUM;
      score_q <= 1'b0;
      cnt_q   <= '0;
      total_q <= '0;
      hit_q   <= '0;
      last_q  <= '0;
      sat_q   <= 1'b0;
      grade_q <= '0;
      num_q   <= '0;
      div_q   <= '0;
      rem_q   <= '0;
      iter_q  <= '0;
    end else if (enable) begin
      state_q <= state_d;
      score_q <= score_d;
      cnt_q   <= cnt_d;
      total_q <= total_d;
      hit_q   <= hit_d;
      last_q  <= last_d;
      sat_q   <= sat_d;
      grade_q <= grade_d;
      num_q   <= num_d;
      div_q   <= div_d;
      rem_q   <= rem_d;
      iter_q  <= iter_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    score_d   = score_ready;
    cnt_d     = cnt_q;
    total_d   = total_q;
    hit_d     = hit_q;
    last_d    = last_q;
    sat_d     = sat_q;
    grade_d   = grade_q;
    num_d     = num_q;
    div_d     = div_q;
    rem_d     = rem_q;
    iter_d    = iter_q;
    rem_shift = {rem_q[9:0], num_q[16]};
    q_bit     = 1'b0;

    if (song_start) begin
      state_d = ACCUM;
      cnt_d   = '0;
      total_d = '0;
      hit_d   = '0;
      last_d  = '0;
      sat_d   = 1'b0;
      grade_d = '0;
    end else begin
      unique case (state_q)
        ACCUM: begin
          // The accept is applied even when song_end arrives in the same cycle.
          if (accept) begin
            if (cnt_q < NOTE_LIMIT) begin
              cnt_d   = cnt_q + 10'd1;
              total_d = total_q + {10'b0, score_c};
              last_d  = score_c;
              if (score_c == 4'd10) hit_d = hit_q + 10'd1;
            end else begin
              sat_d = 1'b1;
            end
          end
          if (song_end) state_d = LOAD;
        end
        LOAD: begin
          if (cnt_q == 10'd0) begin
            grade_d = '0;
            state_d = DONE;
          end else begin
            num_d   = (total_ext << 3) + (total_ext << 1);
            div_d   = cnt_q;
            rem_d   = '0;
            iter_d  = '0;
            state_d = DIVIDE;
          end
        end
        DIVIDE: begin
          // The numerator register shifts out dividend bits and shifts in quotient bits.
          if (rem_shift >= {1'b0, div_q}) begin
            rem_d = rem_shift - {1'b0, div_q};
            q_bit = 1'b1;
          end else begin
            rem_d = rem_shift;
          end
          num_d  = {num_q[15:0], q_bit};
          iter_d = iter_q + 5'd1;
          if (iter_q == 5'd16) begin
            grade_d = {num_q[5:0], q_bit};
            state_d = DONE;
          end
        end
        DONE: ;
        default: state_d = ACCUM;
      endcase
    end
  end

  assign note_count    = cnt_q;
  assign total         = total_q;
  assign hit_count     = hit_q;
  assign last_score    = last_q;
  assign saturated     = sat_q;
  assign grade_percent = grade_q;
  assign busy          = (state_q == LOAD) || (state_q == DIVIDE);
  assign grade_valid   = (state_q == DONE);

endmodule

// File: tb/tb_score_accumulator.sv
// Directed bench for score_accumulator: a default instance and a NOTE_MAX=3
// instance share stimulus; expected values are hand-computed.
module tb_score_accumulator;

  logic       clk, rst, enable, song_start, song_end, score_ready;
  logic [3:0] score;

  logic [9:0]  note_count, hit_count;
  logic [13:0] total;
  logic [3:0]  last_score;
  logic        saturated, busy, grade_valid;
  logic [6:0]  grade_percent;

  logic [9:0]  s_note_count, s_hit_count;
  logic [13:0] s_total;
  logic [3:0]  s_last_score;
  logic        s_saturated, s_busy, s_grade_valid;
  logic [6:0]  s_grade_percent;

  int checks = 0;
  int failures = 0;
  int k;

  score_accumulator dut (
    .clk(clk), .rst(rst), .enable(enable), .song_start(song_start),
    .song_end(song_end), .score_ready(score_ready), .score(score),
    .note_count(note_count), .total(total), .hit_count(hit_count),
    .last_score(last_score), .saturated(saturated), .busy(busy),
    .grade_percent(grade_percent), .grade_valid(grade_valid)
  );

  score_accumulator #(.NOTE_MAX(3)) dut_sat (
    .clk(clk), .rst(rst), .enable(enable), .song_start(song_start),
    .song_end(song_end), .score_ready(score_ready), .score(score),
    .note_count(s_note_count), .total(s_total), .hit_count(s_hit_count),
    .last_score(s_last_score), .saturated(s_saturated), .busy(s_busy),
    .grade_percent(s_grade_percent), .grade_valid(s_grade_valid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end else begin
      $display("ok   %s = %0d", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [3:0] v);
    score = v;
    score_ready = 1'b1;
    tick();
    score_ready = 1'b0;
    tick();
  endtask

  task automatic start_song();
    song_start = 1'b1;
    tick();
    song_start = 1'b0;
  endtask

  task automatic end_song();
    song_end = 1'b1;
    tick();
    song_end = 1'b0;
  endtask

  // k counts cycles after the song_end edge; bounded so a stuck divider still ends.
  task automatic wait_done(input int start, output int kk);
    kk = start;
    while (!grade_valid && kk < 40) begin
      tick();
      kk++;
    end
  endtask

  initial begin
    rst = 1'b1; enable = 1'b1; song_start = 1'b0; song_end = 1'b0;
    score_ready = 1'b0; score = 4'd0;
    tick(); tick();
    rst = 1'b0;
    check("reset_outputs", {note_count, total, hit_count, last_score, saturated,
                            busy, grade_percent, grade_valid}, 0);

    // 10, 7, 5, 0 -> 22 over 4 notes, grade 55 after 19 cycles
    pulse(10); pulse(7); pulse(5); pulse(0);
    check("t1_count", note_count, 4);
    check("t1_total", total, 22);
    check("t1_hits", hit_count, 1);
    check("t1_last", last_score, 0);
    end_song();
    check("t1_busy", busy, 1);
    wait_done(1, k);
    check("t1_latency", k, 19);
    check("t1_grade", grade_percent, 55);
    check("t1_busy_fall", busy, 0);

    // held score_ready counts once
    start_song();
    check("t2_cleared", {note_count, total, grade_percent, grade_valid}, 0);
    pulse(10);
    score = 4'd10; score_ready = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    score_ready = 1'b0; tick();
    pulse(7);
    check("t2_count", note_count, 3);
    check("t2_total", total, 27);
    check("t2_hits", hit_count, 2);
    end_song();
    wait_done(1, k);
    check("t2_grade", grade_percent, 90);

    // empty song
    start_song();
    end_song();
    check("t3_busy_load", busy, 1);
    wait_done(1, k);
    check("t3_latency", k, 2);
    check("t3_grade", grade_percent, 0);
    check("t3_busy_done", busy, 0);

    // accept coincident with song_end is included; accepts while busy/done ignored
    start_song();
    pulse(0);
    score = 4'd10; score_ready = 1'b1; song_end = 1'b1;
    tick();
    score_ready = 1'b0; song_end = 1'b0;
    check("t4_count", note_count, 2);
    check("t4_total", total, 10);
    tick();
    pulse(7);
    check("t4_div_count", note_count, 2);
    check("t4_div_last", last_score, 10);
    wait_done(4, k);
    check("t4_latency", k, 19);
    check("t4_grade", grade_percent, 50);
    pulse(5);
    check("t4_done_count", note_count, 2);
    check("t4_done_hold", {grade_valid, grade_percent}, {1'b1, 7'd50});

    // enable low holds everything; out-of-range score clamps to 10
    start_song();
    enable = 1'b0;
    pulse(10);
    enable = 1'b1;
    tick();
    check("t5_disabled", note_count, 0);
    pulse(13);
    check("t5_clamp_last", last_score, 10);
    check("t5_clamp_total", total, 10);
    check("t5_clamp_hits", hit_count, 1);

    // saturation at NOTE_MAX=3
    start_song();
    for (int i = 0; i < 4; i++) pulse(7);
    check("t6_sat_count", s_note_count, 3);
    check("t6_sat_total", s_total, 21);
    check("t6_sat_flag", s_saturated, 1);
    check("t6_main_count", note_count, 4);
    check("t6_main_flag", saturated, 0);
    end_song();
    wait_done(1, k);
    check("t6_main_grade", grade_percent, 70);
    check("t6_sat_done", {s_grade_valid, s_grade_percent}, {1'b1, 7'd70});
    start_song();
    check("t6_sat_cleared", {s_note_count, s_total, s_hit_count, s_last_score,
                             s_saturated, s_busy, s_grade_percent, s_grade_valid}, 0);

    // rst during DIVIDE cycle 8 aborts
    start_song();
    pulse(10); pulse(5);
    end_song();
    for (int i = 0; i < 8; i++) tick();
    check("t7_in_divide", busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t7_after_rst", {note_count, total, hit_count, busy, grade_valid, grade_percent}, 0);
    pulse(5);
    end_song();
    wait_done(1, k);
    check("t7_latency", k, 19);
    check("t7_grade", grade_percent, 50);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
